// File: rtl/wb_pipe_reg_pkg.sv
// Shared types for the execute-to-writeback pipeline register: occupancy states,
// default widths, the writeback bundle and the register-0 write guard.
package wb_pipe_reg_pkg;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_SEL_W  = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_MAIN  = 2'b01,
    ST_FULL  = 2'b10
  } wb_state_e;

  typedef struct packed {
    logic [PKG_DATA_W-1:0] data;
    logic [PKG_SEL_W-1:0]  sel;
    logic                  we;
  } wb_bundle_t;

  function automatic logic guard_we(input logic we, input logic sel_zero, input logic zero_guard);
    guard_we = we & ~(zero_guard & sel_zero);
  endfunction

endpackage

// File: rtl/wb_fwd_cmp.sv
// Single-selector forwarding compare: flags the held result as bypass source for one read port.
module wb_fwd_cmp
  import wb_pipe_reg_pkg::*;
#(
  parameter int SEL_W      = PKG_SEL_W,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic             valid,
  input  logic             we,
  input  logic [SEL_W-1:0] sel,
  input  logic [SEL_W-1:0] rs,
  output logic             hit
);

  logic rs_ok_s;

  // Register 0 is hard-wired in the register file, so it is never a bypass target when guarded.
  assign rs_ok_s = (ZERO_GUARD == 1'b0) || (rs != {SEL_W{1'b0}});
  assign hit     = valid & we & (sel == rs) & rs_ok_s;

endmodule

// File: rtl/wb_pipe_reg.sv
// Execute-to-writeback pipeline register with a 2-entry skid buffer, flush,
// register-0 write guard and forwarding-hit outputs for the operand bypass.
module wb_pipe_reg
  import wb_pipe_reg_pkg::*;
#(
  parameter int DATA_W     = PKG_DATA_W,
  parameter int SEL_W      = PKG_SEL_W,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ALUOUT,
  input  logic [SEL_W-1:0]  WS,
  input  logic              WE,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] RESU,
  output logic [SEL_W-1:0]  WSP,
  output logic              WEP,
  input  logic [SEL_W-1:0]  RS1,
  input  logic [SEL_W-1:0]  RS2,
  output logic              FWD1_HIT,
  output logic              FWD2_HIT
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              we;
  } entry_t;

  wb_state_e state_r, state_s;
  entry_t    main_r, skid_r, in_entry_s, main_next_s;
  logic      out_valid_r, in_ready_r, wep_r;
  logic      accept_s, drain_s;
  logic      load_main_in_s, load_main_skid_s, load_skid_s;

  assign accept_s = in_valid & in_ready_r;
  assign drain_s  = out_valid_r & out_ready;

  assign in_entry_s.data = ALUOUT;
  assign in_entry_s.sel  = WS;
  assign in_entry_s.we   = guard_we(WE, (WS == {SEL_W{1'b0}}), ZERO_GUARD);

  // Next-state and entry-load decode; flush wins over accept and drain.
  always_comb begin
    state_s          = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_s        = ST_MAIN;
            load_main_in_s = 1'b1;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_MAIN: begin
          if (accept_s && drain_s) begin
            state_s        = ST_MAIN;
            load_main_in_s = 1'b1;
          end else if (accept_s) begin
            state_s     = ST_FULL;
            load_skid_s = 1'b1;
          end else if (drain_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_MAIN;
          end
        end
        ST_FULL: begin
          if (drain_s) begin
            state_s          = ST_MAIN;
            load_main_skid_s = 1'b1;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Select what the main entry holds after this edge.
  always_comb begin
    main_next_s = main_r;
    if (load_main_in_s) begin
      main_next_s = in_entry_s;
    end else if (load_main_skid_s) begin
      main_next_s = skid_r;
    end else begin
      main_next_s = main_r;
    end
  end

  // State and registered handshake/qualifier outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      wep_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s != ST_EMPTY);
      in_ready_r  <= (state_s != ST_FULL);
      wep_r       <= main_next_s.we & (state_s != ST_EMPTY);
    end
  end

  // Main and skid payload storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_r <= '0;
      skid_r <= '0;
    end else begin
      main_r <= main_next_s;
      if (load_skid_s) begin
        skid_r <= in_entry_s;
      end
    end
  end

  assign RESU      = main_r.data;
  assign WSP       = main_r.sel;
  assign WEP       = wep_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;

  wb_fwd_cmp #(.SEL_W(SEL_W), .ZERO_GUARD(ZERO_GUARD)) u_fwd1 (
    .valid (out_valid_r),
    .we    (wep_r),
    .sel   (main_r.sel),
    .rs    (RS1),
    .hit   (FWD1_HIT)
  );

  wb_fwd_cmp #(.SEL_W(SEL_W), .ZERO_GUARD(ZERO_GUARD)) u_fwd2 (
    .valid (out_valid_r),
    .we    (wep_r),
    .sel   (main_r.sel),
    .rs    (RS2),
    .hit   (FWD2_HIT)
  );

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed-vector bench for wb_pipe_reg: reset, streaming, backpressure, zero guard, flush, forwarding.
module tb_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, WE, flush, out_valid, out_ready, WEP;
  logic [31:0] ALUOUT, RESU;
  logic [4:0]  WS, WSP, RS1, RS2;
  logic        FWD1_HIT, FWD2_HIT;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  wb_pipe_reg #(.DATA_W(32), .SEL_W(5), .ZERO_GUARD(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOUT(ALUOUT), .WS(WS), .WE(WE), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .RESU(RESU), .WSP(WSP), .WEP(WEP),
    .RS1(RS1), .RS2(RS2), .FWD1_HIT(FWD1_HIT), .FWD2_HIT(FWD2_HIT)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; ALUOUT = 32'hDEAD_BEEF; WS = 5'd5; WE = 1'b1;
    flush = 1'b0; out_ready = 1'b0; RS1 = 5'd0; RS2 = 5'd0;
    tick();
    tick();
    vectors++; if (RESU !== 32'h0) begin miscompares++; $display("FAIL reset_resu: got %h, expected %h", RESU, 32'h0); end
    vectors++; if (WSP !== 5'd0) begin miscompares++; $display("FAIL reset_wsp: got %0d, expected %0d", WSP, 5'd0); end
    vectors++; if (WEP !== 1'b0) begin miscompares++; $display("FAIL reset_wep: got %b, expected %b", WEP, 1'b0); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, expected %b", out_valid, 1'b0); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, expected %b", in_ready, 1'b1); end
  endtask

  task automatic test_stream();
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; ALUOUT = 32'h11; WS = 5'd3; WE = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid0: got %b, expected %b", out_valid, 1'b1); end
    vectors++; if (RESU !== 32'h11) begin miscompares++; $display("FAIL stream_resu0: got %h, expected %h", RESU, 32'h11); end
    vectors++; if (WSP !== 5'd3) begin miscompares++; $display("FAIL stream_wsp0: got %0d, expected %0d", WSP, 5'd3); end
    vectors++; if (WEP !== 1'b1) begin miscompares++; $display("FAIL stream_wep0: got %b, expected %b", WEP, 1'b1); end
    ALUOUT = 32'h22; WS = 5'd4;
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid1: got %b, expected %b", out_valid, 1'b1); end
    vectors++; if (RESU !== 32'h22) begin miscompares++; $display("FAIL stream_resu1: got %h, expected %h", RESU, 32'h22); end
    vectors++; if (WSP !== 5'd4) begin miscompares++; $display("FAIL stream_wsp1: got %0d, expected %0d", WSP, 5'd4); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready: got %b, expected %b", in_ready, 1'b1); end
    in_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drained: got %b, expected %b", out_valid, 1'b0); end
    vectors++; if (WEP !== 1'b0) begin miscompares++; $display("FAIL stream_wep_idle: got %b, expected %b", WEP, 1'b0); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; ALUOUT = 32'h100; WS = 5'd1; WE = 1'b1;
    tick();
    vectors++; if (RESU !== 32'h100) begin miscompares++; $display("FAIL bp_resu_a: got %h, expected %h", RESU, 32'h100); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_main: got %b, expected %b", in_ready, 1'b1); end
    ALUOUT = 32'h200; WS = 5'd2;
    tick();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_full: got %b, expected %b", in_ready, 1'b0); end
    vectors++; if (RESU !== 32'h100) begin miscompares++; $display("FAIL bp_resu_hold: got %h, expected %h", RESU, 32'h100); end
    ALUOUT = 32'h300; WS = 5'd6;
    tick();
    vectors++; if (RESU !== 32'h100) begin miscompares++; $display("FAIL bp_resu_stable: got %h, expected %h", RESU, 32'h100); end
    vectors++; if (WSP !== 5'd1) begin miscompares++; $display("FAIL bp_wsp_stable: got %0d, expected %0d", WSP, 5'd1); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_stall: got %b, expected %b", in_ready, 1'b0); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    vectors++; if (RESU !== 32'h200) begin miscompares++; $display("FAIL bp_resu_b: got %h, expected %h", RESU, 32'h200); end
    vectors++; if (WSP !== 5'd2) begin miscompares++; $display("FAIL bp_wsp_b: got %0d, expected %0d", WSP, 5'd2); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after: got %b, expected %b", in_ready, 1'b1); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_b: got %b, expected %b", out_valid, 1'b1); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_extra: got %b, expected %b", out_valid, 1'b0); end
  endtask

  task automatic test_zero_guard();
    out_ready = 1'b0; in_valid = 1'b1; ALUOUT = 32'h55; WS = 5'd0; WE = 1'b1; RS1 = 5'd0;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL zg_valid: got %b, expected %b", out_valid, 1'b1); end
    vectors++; if (RESU !== 32'h55) begin miscompares++; $display("FAIL zg_resu: got %h, expected %h", RESU, 32'h55); end
    vectors++; if (WEP !== 1'b0) begin miscompares++; $display("FAIL zg_wep: got %b, expected %b", WEP, 1'b0); end
    vectors++; if (FWD1_HIT !== 1'b0) begin miscompares++; $display("FAIL zg_fwd1: got %b, expected %b", FWD1_HIT, 1'b0); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; ALUOUT = 32'hA1; WS = 5'd9; WE = 1'b1;
    tick();
    ALUOUT = 32'hB2; WS = 5'd10;
    tick();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_pre_full: got %b, expected %b", in_ready, 1'b0); end
    flush = 1'b1; out_ready = 1'b1; ALUOUT = 32'hC3; WS = 5'd11;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b, expected %b", out_valid, 1'b0); end
    vectors++; if (WEP !== 1'b0) begin miscompares++; $display("FAIL flush_wep: got %b, expected %b", WEP, 1'b0); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready: got %b, expected %b", in_ready, 1'b1); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped: got %b, expected %b", out_valid, 1'b0); end
  endtask

  task automatic test_forwarding();
    out_ready = 1'b0; in_valid = 1'b1; ALUOUT = 32'h77; WS = 5'd7; WE = 1'b1; RS1 = 5'd7; RS2 = 5'd8;
    tick();
    in_valid = 1'b0;
    vectors++; if (WEP !== 1'b1) begin miscompares++; $display("FAIL fwd_wep: got %b, expected %b", WEP, 1'b1); end
    vectors++; if (FWD1_HIT !== 1'b1) begin miscompares++; $display("FAIL fwd1_hit: got %b, expected %b", FWD1_HIT, 1'b1); end
    vectors++; if (FWD2_HIT !== 1'b0) begin miscompares++; $display("FAIL fwd2_miss: got %b, expected %b", FWD2_HIT, 1'b0); end
    RS2 = 5'd7; RS1 = 5'd6;
    #1;
    vectors++; if (FWD2_HIT !== 1'b1) begin miscompares++; $display("FAIL fwd2_hit: got %b, expected %b", FWD2_HIT, 1'b1); end
    vectors++; if (FWD1_HIT !== 1'b0) begin miscompares++; $display("FAIL fwd1_miss: got %b, expected %b", FWD1_HIT, 1'b0); end
    RS1 = 5'd7; RS2 = 5'd8; out_ready = 1'b1;
    tick();
    vectors++; if (FWD1_HIT !== 1'b0) begin miscompares++; $display("FAIL fwd1_after_drain: got %b, expected %b", FWD1_HIT, 1'b0); end
    vectors++; if (FWD2_HIT !== 1'b0) begin miscompares++; $display("FAIL fwd2_after_drain: got %b, expected %b", FWD2_HIT, 1'b0); end
    out_ready = 1'b0; in_valid = 1'b1; WE = 1'b0;
    tick();
    in_valid = 1'b0;
    vectors++; if (FWD1_HIT !== 1'b0) begin miscompares++; $display("FAIL fwd1_no_we: got %b, expected %b", FWD1_HIT, 1'b0); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1; ALUOUT = 32'hE1; WS = 5'd12; WE = 1'b1;
    tick();
    ALUOUT = 32'hE2; WS = 5'd13;
    tick();
    rst = 1'b0; flush = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_stall_valid: got %b, expected %b", out_valid, 1'b0); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_stall_ready: got %b, expected %b", in_ready, 1'b1); end
    vectors++; if (RESU !== 32'h0) begin miscompares++; $display("FAIL rst_stall_resu: got %h, expected %h", RESU, 32'h0); end
    vectors++; if (WSP !== 5'd0) begin miscompares++; $display("FAIL rst_stall_wsp: got %0d, expected %0d", WSP, 5'd0); end
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_stall_skid_gone: got %b, expected %b", out_valid, 1'b0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_guard();
    test_flush();
    test_forwarding();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_pipe_reg.md
Name: wb_pipe_reg

Overview:
Parametrised execute-to-writeback pipeline register, the successor to our fixed 32-bit/5-bit stage register. Adds a valid/ready handshake with a 2-entry skid buffer, so downstream stalls do not drop results and the upstream ready stays registered. Also adds a synchronous flush, a write-enable guard for register 0, and two forwarding-hit outputs for the operand bypass muxes. It sits between the ALU stage and the register-file write port.

Parameters:
DATA_W, 32, result width (ALUOUT/RESU)
SEL_W, 5, register-select width (WS/WSP, RS1/RS2)
ZERO_GUARD, 1, when 1, writes and forwarding to register 0 are suppressed

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
in_valid  in  1  upstream result valid
in_ready  out  1  stage can accept a result this cycle (registered)
ALUOUT  in  DATA_W  ALU result
WS  in  SEL_W  destination register select
WE  in  1  register write enable
flush  in  1  discard all held entries
out_valid  out  1  RESU/WSP/WEP hold a valid result
out_ready  in  1  writeback consumes the result this cycle
RESU  out  DATA_W  held result
WSP  out  SEL_W  held destination select
WEP  out  1  effective write enable = held WE & out_valid
RS1  in  SEL_W  operand-1 read select (forwarding compare)
RS2  in  SEL_W  operand-2 read select
FWD1_HIT  out  1  RESU is the bypass source for RS1
FWD2_HIT  out  1  RESU is the bypass source for RS2

Behaviour:
- Reset (rst==0 at posedge): RESU=0, WSP=0, WEP=0, out_valid=0, skid entry cleared, in_ready=1 on the next cycle. Reset overrides flush and all transfers, including mid-stall.
- Storage: main entry (drives outputs) and skid entry. States: EMPTY (neither valid), MAIN (main only), FULL (main+skid).
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- in_ready = !skid_valid, registered. It is 1 in EMPTY and MAIN and 0 in FULL.
- Transitions:
  - EMPTY + accept -> MAIN, main loads the input.
  - MAIN + accept & drain -> MAIN, main loads the input.
  - MAIN + accept & !drain -> FULL, skid loads the input and main holds.
  - MAIN + drain & !accept -> EMPTY.
  - FULL + drain -> MAIN, main loads from skid. No accept is possible in FULL.
  - All other cases hold.
- Latency: 1 cycle from accept to out_valid when main is free or draining. Throughput is 1 result/cycle while out_ready=1.
- Ordering is strictly FIFO. Output fields are stable while out_valid & !out_ready.
- ZERO_GUARD=1: WE is captured as WE & (WS!=0). WEP is therefore never 1 with WSP==0.
- flush=1 at posedge: both entries invalidated, state -> EMPTY, WEP=0. An input offered the same cycle is dropped. RESU/WSP may retain stale data but are qualified by out_valid. Flush has priority over accept and drain.
- WEP = main_we & out_valid. It is never 1 when out_valid=0.
- Forwarding (combinational from main only): FWDn_HIT = out_valid & WEP & (WSP==RSn) & (!ZERO_GUARD | RSn!=0). The skid entry is never a forwarding source; upstream stalls via in_ready in FULL.
- No arithmetic; widths pass through unchanged.

Decomposition:
- Shared pipeline package holds: state enum (EMPTY/MAIN/FULL), and a writeback-bundle struct {data DATA_W, sel SEL_W, we}, sized by the package's default DATA_W/SEL_W.
- One natural sub-module: wb_fwd_cmp (single selector compare → hit), instantiated twice for RS1/RS2.

Test Plan:
- Reset: drive rst=0 with in_valid=1, ALUOUT=0xDEAD_BEEF -> next cycle RESU=0, WSP=0, WEP=0, out_valid=0, in_ready=1.
- Streaming: out_ready=1, accept (0x11,WS=3,WE=1) then (0x22,WS=4,WE=1) on back-to-back cycles -> RESU=0x11/WSP=3 then 0x22/WSP=4, one cycle after each accept, no bubbles.
- Backpressure: hold out_ready=0 and send A=0x100, B=0x200 -> state FULL, in_ready=0, RESU=0x100 stable. Then raise out_ready -> 0x100, 0x200 in order, then in_ready=1.
- Zero guard: WS=0, WE=1, ALUOUT=0x55 -> out_valid=1, WEP=0; with RS1=0, FWD1_HIT=0.
- Flush in FULL, with a new input offered the same cycle -> next cycle out_valid=0, WEP=0, in_ready=1, input not captured.
- Forwarding: held WSP=7, WEP=1, RS1=7, RS2=8 -> FWD1_HIT=1, FWD2_HIT=0. After drain with no new input -> both hits 0.
